// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared state encodings, digit width and index sizing for mul_seq_ctrl
package mul_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DIGIT_W = 2;

  // Index registers stay at least one bit wide even when there is a single digit.
  function automatic int idx_w(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/mul2x2.sv
// rtl/mul2x2.sv - combinational 2-bit x 2-bit unsigned multiplier
module mul2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);

  assign p = {2'b00, x} * {2'b00, y};

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - WIDTH x WIDTH sequential multiplier built on one shared mul2x2
// Optional MUL_SEQ_ZERO_SKIP_EN: a zero operand finishes after a single RUN cycle.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int D     = WIDTH / DIGIT_W;
  localparam int ACC_W = 2 * WIDTH;
  localparam int IDX_W = idx_w(D);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]   i_idx;
  logic [IDX_W-1:0]   j_idx;

  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [3:0]         pp;
  logic [IDX_W:0]     ij_sum;
  logic [ACC_W-1:0]   pp_sh;
  logic [ACC_W-1:0]   acc_nxt;
  logic               last_iter;
  logic               skip;

  assign a_dig = DIGIT_W'(a_reg >> {i_idx, 1'b0});
  assign b_dig = DIGIT_W'(b_reg >> {j_idx, 1'b0});

  mul2x2 u_mul2x2 (
    .x (a_dig),
    .y (b_dig),
    .p (pp)
  );

  // Partial product weight is 4^(i+j), i.e. a left shift by 2*(i+j).
  assign ij_sum    = {1'b0, i_idx} + {1'b0, j_idx};
  assign pp_sh     = ACC_W'(pp) << {ij_sum, 1'b0};
  assign acc_nxt   = acc + pp_sh;
  assign last_iter = (i_idx == LAST) && (j_idx == LAST);

`ifdef MUL_SEQ_ZERO_SKIP_EN
  logic zero_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_op <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      zero_op <= (a == '0) || (b == '0);
    end
  end

  assign skip = zero_op;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (skip) begin
            product <= '0;
            state   <= ST_DONE;
          end else begin
            acc <= acc_nxt;
            if (j_idx == LAST) begin
              j_idx <= '0;
              i_idx <= i_idx + 1'b1;
            end else begin
              j_idx <= j_idx + 1'b1;
            end
            if (last_iter) begin
              product <= acc_nxt;
              state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed vector bench for mul_seq_ctrl (WIDTH=8)
module tb_mul_seq_ctrl;

  localparam int N_ITER = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks;
  int n_fails;
  logic [15:0] last_p;

  mul_seq_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] exp_p;
    bit          zero_op;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full operation; done is sampled at the negedge after each edge T+k.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] ep, input int lat, input string nm);
    int first;
    int cnt;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_at_accept"}, 32'(busy), 32'd1);
    chk({nm, "_product_held"}, 32'(product), 32'(last_p));
    first = -1;
    cnt = 0;
    for (int k = 1; k <= N_ITER + 6; k++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    chk({nm, "_latency"}, 32'(first), 32'(lat));
    chk({nm, "_done_count"}, 32'(cnt), 32'd1);
    chk({nm, "_product"}, 32'(product), 32'(ep));
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    last_p = ep;
  endtask

  initial begin
    int first;
    int second;
    int cnt;
    int zlat;

`ifdef MUL_SEQ_ZERO_SKIP_EN
    zlat = 1;
`else
    zlat = N_ITER;
`endif

    vecs[0] = '{8'h03, 8'h02, 16'h0006, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[2] = '{8'hA5, 8'h3C, 16'h26AC, 1'b0};
    vecs[3] = '{8'h10, 8'h10, 16'h0100, 1'b0};
    vecs[4] = '{8'h01, 8'h01, 16'h0001, 1'b0};
    vecs[5] = '{8'h00, 8'h55, 16'h0000, 1'b1};
    vecs[6] = '{8'h80, 8'h00, 16'h0000, 1'b1};

    n_checks = 0;
    n_fails = 0;
    last_p = 16'h0000;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    rst = 1'b0;

    cnt = 0;
    a = 8'hFF;
    b = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    chk("idle_no_activity", 32'(cnt), 32'd0);
    chk("idle_product", 32'(product), 32'd0);

    for (int v = 0; v < 7; v++) begin
      do_op(vecs[v].av, vecs[v].bv, vecs[v].exp_p,
            vecs[v].zero_op ? zlat : N_ITER, $sformatf("vec%0d", v));
    end

    // Start pulses and operand changes while running must not disturb the latched operation.
    @(negedge clk);
    a = 8'hA5;
    b = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first = -1;
    cnt = 0;
    for (int k = 1; k <= N_ITER + 6; k++) begin
      if (k == 3) begin a = 8'hFF; b = 8'h11; start = 1'b1; end
      if (k == 5) start = 1'b0;
      if (k == 9) begin a = 8'h00; start = 1'b1; end
      if (k == 10) start = 1'b0;
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    chk("interfere_latency", 32'(first), 32'(N_ITER));
    chk("interfere_done_count", 32'(cnt), 32'd1);
    chk("interfere_product", 32'(product), 32'h26AC);

    // Held start: second operation accepted on the first IDLE cycle after DONE.
    @(negedge clk);
    a = 8'h03;
    b = 8'h05;
    start = 1'b1;
    first = -1;
    second = -1;
    for (int k = 0; k <= 2 * (N_ITER + 2) + 1; k++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    start = 1'b0;
    chk("b2b_first", 32'(first), 32'(N_ITER));
    chk("b2b_cadence", 32'(second - first), 32'(N_ITER + 2));
    chk("b2b_product", 32'(product), 32'h000F);

    // Abort mid-run: a third operation is in progress here; start a fresh one and reset at T+5.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_p = 16'h0000;
    do_op(8'h03, 8'h02, 16'h0006, N_ITER, "pre_abort");
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < N_ITER + 4; k++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    last_p = 16'h0000;
    do_op(8'h10, 8'h10, 16'h0100, N_ITER, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
